regfile_mp: RTL

Parametrised multi-port register file, the next-generation general-purpose register array for the rv32i cores. It provides NUM_RD synchronous (registered) read ports, NUM_WR write ports with fixed priority, a hardwired zero register and a per-register busy scoreboard for the decode stage. The block sits between decode (reads and allocates) and writeback (writes and releases).

---
 rtl/regfile_mp.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, prioritised writes, hardwired x0 and a busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; the default build is read-first.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       alloc_en,
    input  logic [ADDR_W-1:0]          alloc_addr
);

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [DATA_W-1:0] regs_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [DATA_W-1:0] rd_val   [NUM_RD];
    logic [NUM_RD-1:0] rd_busy_val;

    // x0 and out-of-range addresses are never writable or allocatable.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS);
    endfunction

    function automatic logic readable(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Ascending port loop lets the higher write port win; alloc is applied last so it wins over write.
    always_comb begin
        regs_nxt = regs;
        busy_nxt = busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && writable(wr_addr[w*ADDR_W +: ADDR_W])) begin
                regs_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
                busy_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (alloc_en && writable(alloc_addr)) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_val[p]      = '0;
            rd_busy_val[p] = 1'b0;
            if (readable(rd_addr[p*ADDR_W +: ADDR_W])) begin
                rd_val[p]      = regs[rd_addr[p*ADDR_W +: ADDR_W]];
                rd_busy_val[p] = busy[rd_addr[p*ADDR_W +: ADDR_W]];
            end
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && writable(wr_addr[w*ADDR_W +: ADDR_W]) &&
                    (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])) begin
                    rd_val[p] = wr_data[w*DATA_W +: DATA_W];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            regs <= regs_nxt;
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p*DATA_W +: DATA_W] <= rd_val[p];
                    rd_busy[p]                  <= rd_busy_val[p];
                end
            end
        end
    end

endmodule
